exe_wb_skid: RTL and testbench

//  Two-entry valid/ready skid buffer between the execute stage (ALU result + branch decision) and writeback/PC-update.

---
 rtl/exe_wb_skid.sv | 131 +++++++++++++
 tb/tb_exe_wb_skid.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exe_wb_skid.sv
// Two-entry skid buffer between execute and writeback/PC-update. in_ready_o is a flop, so
// out_ready_i never reaches the execute stage combinationally. Define EXE_WB_FWD_EN to add the forwarding tap.
module exe_wb_skid #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_result_i,
  input  logic               in_jump_i,
  input  logic [DATA_W-1:0]  in_target_i,
  input  logic               in_wen_i,
  input  logic [RADDR_W-1:0] in_rd_addr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_result_o,
  output logic               out_jump_o,
  output logic [DATA_W-1:0]  out_target_o,
  output logic               out_wen_o,
  output logic [RADDR_W-1:0] out_rd_addr_o,
`ifdef EXE_WB_FWD_EN
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0]  fwd_data_o,
`endif
  output logic [1:0]         count_o
);

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic               jump;
    logic [DATA_W-1:0]  target;
    logic               wen;
    logic [RADDR_W-1:0] rd;
  } entry_t;

  // The state encoding equals the occupancy, so count_o doubles as the state debug view.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e state_q;
  entry_t main_q, skid_q, in_entry;
  logic   in_ready_q;
  logic   main_valid, skid_valid, push, pop;

  // Handshake: a transfer occurs on a side in any cycle where both valid and ready are high.
  // Valid never depends on ready, and ready never depends on valid on the same side.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);
  assign push       = in_valid_i & in_ready_q;
  assign pop        = main_valid & out_ready_i;

  // x0 is hardwired, so a write to it is stored as a non-write.
  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result_i;
    in_entry.jump   = in_jump_i;
    in_entry.target = in_target_i;
    in_entry.wen    = in_wen_i & (in_rd_addr_i != '0);
    in_entry.rd     = in_rd_addr_i;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          main_q  <= in_entry;
          state_q <= ONE;
        end
        ONE: begin
          if (push && !pop) begin
            skid_q     <= in_entry;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (push && pop) begin
            main_q <= in_entry;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        TWO: if (pop) begin
          main_q     <= skid_q;
          state_q    <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = main_valid;
  assign out_result_o  = main_valid ? main_q.result : '0;
  assign out_jump_o    = main_valid & main_q.jump;
  assign out_target_o  = main_valid ? main_q.target : '0;
  assign out_wen_o     = main_valid & main_q.wen;
  assign out_rd_addr_o = main_valid ? main_q.rd : '0;
  assign count_o       = state_q;

`ifdef EXE_WB_FWD_EN
  // The skid entry is younger than main, so it wins when both write.
  always_comb begin
    fwd_valid_o = 1'b0;
    fwd_addr_o  = '0;
    fwd_data_o  = '0;
    if (skid_valid && skid_q.wen) begin
      fwd_valid_o = 1'b1;
      fwd_addr_o  = skid_q.rd;
      fwd_data_o  = skid_q.result;
    end else if (main_valid && main_q.wen) begin
      fwd_valid_o = 1'b1;
      fwd_addr_o  = main_q.rd;
      fwd_data_o  = main_q.result;
    end
  end
`endif

endmodule

// File: tb/tb_exe_wb_skid.sv
// Directed bench for exe_wb_skid: reset, single transfer, stall ordering, x0 write, flush, jump/reset,
// and the forwarding tap when EXE_WB_FWD_EN is defined.
module tb_exe_wb_skid;
  logic        clk = 1'b0;
  logic        n_reset, flush_i, in_valid_i, in_ready_o, in_jump_i, in_wen_i;
  logic [31:0] in_result_i, in_target_i;
  logic [4:0]  in_rd_addr_i;
  logic        out_valid_o, out_ready_i, out_jump_o, out_wen_o;
  logic [31:0] out_result_o, out_target_o;
  logic [4:0]  out_rd_addr_o;
  logic [1:0]  count_o;
`ifdef EXE_WB_FWD_EN
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  exe_wb_skid #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .n_reset(n_reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_result_i(in_result_i),
    .in_jump_i(in_jump_i), .in_target_i(in_target_i), .in_wen_i(in_wen_i),
    .in_rd_addr_i(in_rd_addr_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_jump_o(out_jump_o), .out_target_o(out_target_o),
    .out_wen_o(out_wen_o), .out_rd_addr_o(out_rd_addr_o),
`ifdef EXE_WB_FWD_EN
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
`endif
    .count_o(count_o)
  );

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic wen);
    in_valid_i   = v;
    in_result_i  = res;
    in_rd_addr_i = rd;
    in_wen_i     = wen;
    in_jump_i    = 1'b0;
    in_target_i  = 32'h0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    cyc(); cyc();
    vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    vectors++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    vectors++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
    vectors++; if (out_result_o !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", out_result_o); end
    n_reset = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    out_ready_i = 1'b1;
    drive(1'b1, 32'h1234, 5'd3, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid_o); end
    vectors++; if (out_result_o !== 32'h1234) begin errors++; $display("FAIL single_result got=%h exp=1234", out_result_o); end
    vectors++; if (out_rd_addr_o !== 5'd3) begin errors++; $display("FAIL single_rd got=%0d exp=3", out_rd_addr_o); end
    vectors++; if (out_wen_o !== 1'b1) begin errors++; $display("FAIL single_wen got=%b exp=1", out_wen_o); end
    vectors++; if (count_o !== 2'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count_o); end
    cyc();
    vectors++; if (count_o !== 2'd0) begin errors++; $display("FAIL single_drain got=%0d exp=0", count_o); end
    vectors++; if (out_result_o !== 32'h0) begin errors++; $display("FAIL single_zero got=%h exp=0", out_result_o); end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b0;
    drive(1'b1, 32'd5, 5'd1, 1'b1); cyc();
    vectors++; if (count_o !== 2'd1) begin errors++; $display("FAIL b2b_count_a got=%0d exp=1", count_o); end
    drive(1'b1, 32'd6, 5'd1, 1'b1); cyc();
    vectors++; if (count_o !== 2'd2) begin errors++; $display("FAIL b2b_count_b got=%0d exp=2", count_o); end
    vectors++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready got=%b exp=0", in_ready_o); end
    drive(1'b1, 32'd7, 5'd1, 1'b1); cyc();
    vectors++; if (count_o !== 2'd2) begin errors++; $display("FAIL b2b_stall_count got=%0d exp=2", count_o); end
    vectors++; if (out_result_o !== 32'd5) begin errors++; $display("FAIL b2b_head_a got=%0d exp=5", out_result_o); end
    out_ready_i = 1'b1; cyc();
    vectors++; if (out_result_o !== 32'd6) begin errors++; $display("FAIL b2b_head_b got=%0d exp=6", out_result_o); end
    vectors++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_again got=%b exp=1", in_ready_o); end
    cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++; if (out_result_o !== 32'd7) begin errors++; $display("FAIL b2b_head_c got=%0d exp=7", out_result_o); end
    vectors++; if (count_o !== 2'd1) begin errors++; $display("FAIL b2b_count_c got=%0d exp=1", count_o); end
    cyc();
    vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_reg0();
    out_ready_i = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1); cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++; if (out_wen_o !== 1'b0) begin errors++; $display("FAIL reg0_wen got=%b exp=0", out_wen_o); end
    vectors++; if (out_result_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reg0_result got=%h exp=ffffffff", out_result_o); end
    out_ready_i = 1'b1; cyc();
    vectors++; if (count_o !== 2'd0) begin errors++; $display("FAIL reg0_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h11, 5'd4, 1'b1); cyc();
    drive(1'b1, 32'h22, 5'd4, 1'b1); cyc();
    drive(1'b1, 32'h33, 5'd4, 1'b1); flush_i = 1'b1; cyc();
    vectors++; if (count_o !== 2'd0) begin errors++; $display("FAIL flush2_count got=%0d exp=0", count_o); end
    vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush2_valid got=%b exp=0", out_valid_o); end
    vectors++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL flush2_ready got=%b exp=1", in_ready_o); end
    flush_i = 1'b0; drive(1'b0, 32'h0, 5'd0, 1'b0); cyc();
    vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush2_ghost got=%b exp=0", out_valid_o); end
    // With one entry held, the same-cycle push is accepted by ready but must still be dropped.
    drive(1'b1, 32'h44, 5'd4, 1'b1); cyc();
    drive(1'b1, 32'h55, 5'd4, 1'b1); flush_i = 1'b1; cyc();
    flush_i = 1'b0; drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++; if (count_o !== 2'd0) begin errors++; $display("FAIL flush1_count got=%0d exp=0", count_o); end
    vectors++; if (out_result_o !== 32'h0) begin errors++; $display("FAIL flush1_result got=%h exp=0", out_result_o); end
  endtask

  task automatic test_jump_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h9, 5'd7, 1'b1);
    in_jump_i = 1'b1; in_target_i = 32'h40;
    cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++; if (out_jump_o !== 1'b1) begin errors++; $display("FAIL jump_flag got=%b exp=1", out_jump_o); end
    vectors++; if (out_target_o !== 32'h40) begin errors++; $display("FAIL jump_target got=%h exp=40", out_target_o); end
    cyc();
    vectors++; if (out_target_o !== 32'h40) begin errors++; $display("FAIL jump_hold got=%h exp=40", out_target_o); end
    n_reset = 1'b0; cyc();
    vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid_o); end
    vectors++; if (out_jump_o !== 1'b0 || out_target_o !== 32'h0 || out_result_o !== 32'h0 || out_rd_addr_o !== 5'd0)
      begin errors++; $display("FAIL rst_mid_data got=%b/%h/%h/%0d exp=0", out_jump_o, out_target_o, out_result_o, out_rd_addr_o); end
    vectors++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready_o); end
    n_reset = 1'b1; cyc();
  endtask

`ifdef EXE_WB_FWD_EN
  task automatic test_fwd();
    out_ready_i = 1'b0;
    drive(1'b1, 32'hA, 5'd2, 1'b1); cyc();
    drive(1'b1, 32'hB, 5'd2, 1'b1); cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++; if (fwd_valid_o !== 1'b1 || fwd_addr_o !== 5'd2) begin errors++; $display("FAIL fwd_addr got=%b/%0d exp=1/2", fwd_valid_o, fwd_addr_o); end
    vectors++; if (fwd_data_o !== 32'hB) begin errors++; $display("FAIL fwd_young got=%h exp=b", fwd_data_o); end
    out_ready_i = 1'b1; cyc();
    vectors++; if (fwd_data_o !== 32'hB) begin errors++; $display("FAIL fwd_after_pop got=%h exp=b", fwd_data_o); end
    cyc();
    vectors++; if (fwd_valid_o !== 1'b0 || fwd_data_o !== 32'h0) begin errors++; $display("FAIL fwd_empty got=%b/%h exp=0/0", fwd_valid_o, fwd_data_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reg0();
    test_flush();
    test_jump_reset();
`ifdef EXE_WB_FWD_EN
    test_fwd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
